gdma_test_sched: RTL and testbench

//  Sequencer above the gdma core in the memory test model. Splits a test region into
//  cfg_block_num blocks of cfg_block_len bytes and, per block, issues a write and/or read
//  job on the gdma start/done interface. Exactly one gdma job is in flight at a time.

---
 rtl/gdma_test_sched.sv | 175 +++++++++++++++++
 tb/tb_gdma_test_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gdma_test_sched.sv
// gdma_test_sched: splits a test region into blocks and runs one gdma write/read job at a time, with a per-job watchdog.
// Optional feature macro GDMA_SCHED_LOOP_EN adds cfg_loop/pass_cnt for repeated passes until abort or error.
module gdma_test_sched #(
    parameter int ADDR_W = 49,
    parameter int LEN_W  = 32,
    parameter int BLK_W  = 16,
    parameter int TMO_W  = 24
) (
    input  logic              gdma_clk,
    input  logic              gdma_rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [LEN_W-1:0]  cfg_block_len,
    input  logic [BLK_W-1:0]  cfg_block_num,
    input  logic [1:0]        cfg_mode,
    input  logic [TMO_W-1:0]  cfg_timeout,
`ifdef GDMA_SCHED_LOOP_EN
    input  logic              cfg_loop,
    output logic [15:0]       pass_cnt,
`endif
    output logic              gdma_wr_start,
    output logic [ADDR_W-1:0] start_wr_addr,
    output logic [LEN_W-1:0]  wr_length,
    input  logic              gdma_wr_done,
    output logic              gdma_rd_start,
    output logic [ADDR_W-1:0] start_rd_addr,
    output logic [LEN_W-1:0]  rd_length,
    input  logic              gdma_rd_done,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [BLK_W-1:0]  blk_cnt
);
    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, NEXT, FIN} state_t;
    state_t state_q, state_d, first_issue;
    logic [ADDR_W-1:0] base_q, addr_q, addr_d;
    logic [LEN_W-1:0]  len_q;
    logic [BLK_W-1:0]  num_q, blk_q, blk_d;
    logic [1:0]        mode_q;
    logic [TMO_W-1:0]  tmo_q, wdog_q, wdog_d, wdog_inc;
    logic pend_q, pend_d, abort_q, abort_d, error_q, error_d;
    logic accept, expired, last, abort_now;
`ifdef GDMA_SCHED_LOOP_EN
    logic        loop_q;
    logic [15:0] pass_q, pass_d;
    assign pass_cnt = pass_q;
`endif

    assign accept      = state_q == IDLE && cfg_start;
    assign busy        = state_q != IDLE && state_q != FIN;
    assign first_issue = mode_q == 2'b01 ? RD_ISSUE : WR_ISSUE;
    assign wdog_inc    = &wdog_q ? wdog_q : wdog_q + TMO_W'(1);
    // wdog_q counts cycles since the ISSUE cycle; expiry lands FIN exactly timeout cycles after the start pulse
    assign expired     = tmo_q != '0 && wdog_q >= tmo_q - TMO_W'(1);
    assign last        = blk_q + BLK_W'(1) == num_q;
    assign abort_now   = abort_q | cfg_abort;

    assign gdma_wr_start = state_q == WR_ISSUE;
    assign gdma_rd_start = state_q == RD_ISSUE;
    assign start_wr_addr = addr_q;
    assign start_rd_addr = addr_q;
    assign wr_length     = len_q;
    assign rd_length     = len_q;
    assign done          = state_q == FIN;
    assign error         = error_q;
    assign blk_cnt       = blk_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        blk_d   = blk_q;
        wdog_d  = wdog_q;
        pend_d  = 1'b0;
        error_d = error_q;
        abort_d = accept ? cfg_abort : abort_q | (busy & cfg_abort);
`ifdef GDMA_SCHED_LOOP_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            IDLE: if (cfg_start) begin
                addr_d  = cfg_base_addr;
                blk_d   = '0;
                error_d = 1'b0;
`ifdef GDMA_SCHED_LOOP_EN
                pass_d  = '0;
`endif
                state_d = (cfg_block_len == '0 || cfg_block_num == '0) ? FIN :
                          cfg_mode == 2'b01 ? RD_ISSUE : WR_ISSUE;
            end
            WR_ISSUE: begin
                state_d = WR_WAIT;
                wdog_d  = TMO_W'(1);
                pend_d  = gdma_wr_done;
            end
            // a completing done wins over a watchdog expiry in the same cycle
            WR_WAIT: begin
                if (gdma_wr_done | pend_q) state_d = mode_q == 2'b00 ? NEXT : RD_ISSUE;
                else if (expired) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end else wdog_d = wdog_inc;
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                wdog_d  = TMO_W'(1);
                pend_d  = gdma_rd_done;
            end
            RD_WAIT: begin
                if (gdma_rd_done | pend_q) state_d = NEXT;
                else if (expired) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end else wdog_d = wdog_inc;
            end
            NEXT: begin
                blk_d   = blk_q + BLK_W'(1);
                addr_d  = addr_q + ADDR_W'(len_q);
                state_d = (last || abort_now) ? FIN : first_issue;
`ifdef GDMA_SCHED_LOOP_EN
                if (last && loop_q) begin
                    pass_d = &pass_q ? pass_q : pass_q + 16'd1;
                    if (!abort_now) begin
                        blk_d   = '0;
                        addr_d  = base_q;
                        state_d = first_issue;
                    end
                end
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gdma_clk) begin
        if (gdma_rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            num_q   <= '0;
            blk_q   <= '0;
            mode_q  <= '0;
            tmo_q   <= '0;
            wdog_q  <= '0;
            pend_q  <= 1'b0;
            abort_q <= 1'b0;
            error_q <= 1'b0;
`ifdef GDMA_SCHED_LOOP_EN
            loop_q  <= 1'b0;
            pass_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            blk_q   <= blk_d;
            wdog_q  <= wdog_d;
            pend_q  <= pend_d;
            abort_q <= abort_d;
            error_q <= error_d;
`ifdef GDMA_SCHED_LOOP_EN
            pass_q  <= pass_d;
            if (accept) loop_q <= cfg_loop;
`endif
            if (accept) begin
                base_q <= cfg_base_addr;
                len_q  <= cfg_block_len;
                num_q  <= cfg_block_num;
                mode_q <= cfg_mode;
                tmo_q  <= cfg_timeout;
            end
        end
    end
endmodule

// File: tb/tb_gdma_test_sched.sv
// tb_gdma_test_sched: randomized runs against a job-timeline model of the block sequencer.
// Inputs are driven and outputs sampled on the falling clock edge; cycle 0 of a run is the cfg_start cycle.
module tb_gdma_test_sched;
    logic        gdma_clk = 1'b0;
    logic        gdma_rst;
    logic        cfg_start, cfg_abort;
    logic [48:0] cfg_base_addr;
    logic [31:0] cfg_block_len;
    logic [15:0] cfg_block_num;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_timeout;
    logic        gdma_wr_start, gdma_rd_start, gdma_wr_done, gdma_rd_done;
    logic [48:0] start_wr_addr, start_rd_addr;
    logic [31:0] wr_length, rd_length;
    logic        busy, done, error;
    logic [15:0] blk_cnt;
`ifdef GDMA_SCHED_LOOP_EN
    logic        cfg_loop = 1'b0;
    logic [15:0] pass_cnt;
`endif
    int checks = 0, errors = 0;
    bit last_err = 0;
    logic [48:0] q_addr[$];
    bit q_wr[$];
    int fo;

    always #5 gdma_clk = ~gdma_clk;

    gdma_test_sched dut (
        .gdma_clk(gdma_clk), .gdma_rst(gdma_rst),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_base_addr(cfg_base_addr), .cfg_block_len(cfg_block_len),
        .cfg_block_num(cfg_block_num), .cfg_mode(cfg_mode), .cfg_timeout(cfg_timeout),
`ifdef GDMA_SCHED_LOOP_EN
        .cfg_loop(cfg_loop), .pass_cnt(pass_cnt),
`endif
        .gdma_wr_start(gdma_wr_start), .start_wr_addr(start_wr_addr), .wr_length(wr_length),
        .gdma_wr_done(gdma_wr_done),
        .gdma_rd_start(gdma_rd_start), .start_rd_addr(start_rd_addr), .rd_length(rd_length),
        .gdma_rd_done(gdma_rd_done),
        .busy(busy), .done(done), .error(error), .blk_cnt(blk_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [48:0] addr_of(input logic [48:0] b, input logic [31:0] l, input int i);
        logic [63:0] s;
        s = 64'(b) + 64'(l) * 64'(i);
        return s[48:0];
    endfunction

    task automatic drive_cfg(input logic [48:0] b, input logic [31:0] l, input logic [15:0] n,
                             input logic [1:0] m, input logic [23:0] t);
        cfg_base_addr = b;
        cfg_block_len = l;
        cfg_block_num = n;
        cfg_mode      = m;
        cfg_timeout   = t;
    endtask

    // One run: the model predicts the cycle of every start, of done, and the final counts.
    // A job's done takes effect at max(done cycle, start+1); after it comes the read start
    // one cycle later (write-then-read) or block bookkeeping, then the next start two cycles later.
    task automatic run(input logic [48:0] b, input logic [31:0] l, input logic [15:0] n, input logic [1:0] m,
                       input logic [23:0] t, input int fk, input bit hold, input int ab_blk, input bit post,
                       output int fin_off);
        int c, pend_c, fin_c, dc, fend, blk, blk_fin, k, e, late_c;
        bit pend_wr, infl, infl_wr, exp_err, ab, has_wr, has_rd;
        logic [48:0] ia;
        q_addr.delete();
        q_wr.delete();
        has_wr = m != 2'b01;
        has_rd = m != 2'b00;
        c = 0; blk = 0; blk_fin = 0; dc = -1; late_c = -1; fend = -1; ia = '0;
        infl = 0; infl_wr = 0; exp_err = 0; pend_wr = has_wr;
        if (l == 0 || n == 0) begin
            pend_c = -1;
            fin_c  = 1;
        end else begin
            pend_c = 1;
            fin_c  = 1 << 30;
        end
        while (c <= fin_c + 4) begin
            @(negedge gdma_clk);
            ab = 0;
            chk("wr_start", gdma_wr_start, c == pend_c && pend_wr);
            chk("rd_start", gdma_rd_start, c == pend_c && !pend_wr);
            chk("busy", busy, c >= 1 && c < fin_c);
            chk("done", done, c == fin_c);
            chk("error", error, c == 0 ? last_err : (c >= fin_c ? exp_err : 1'b0));
            if (c == fin_c) chk("blk_cnt_end", blk_cnt, blk_fin);
            if (c == pend_c) begin
                chk("blk_cnt_issue", blk_cnt, blk);
                q_wr.push_back(pend_wr);
                q_addr.push_back(pend_wr ? start_wr_addr : start_rd_addr);
                ab = blk == ab_blk;
                infl = 1; infl_wr = pend_wr; ia = addr_of(b, l, blk);
                k = fk >= 0 ? fk : int'($urandom_range(0, 6));
                dc = hold ? -1 : c + k;
                e = dc > c ? dc : c + 1;
                if (t != 0 && (hold || e > c + int'(t) - 1)) begin
                    fin_c = c + int'(t); exp_err = 1; fend = fin_c - 1;
                    blk_fin = blk; pend_c = -1; late_c = hold ? fin_c + 2 : -1;
                end else begin
                    fend = e;
                    if (pend_wr && has_rd) begin
                        pend_c = e + 1; pend_wr = 0;
                    end else if (blk + 1 == int'(n) || (ab_blk >= 0 && blk >= ab_blk)) begin
                        fin_c = e + 2; blk_fin = blk + 1; pend_c = -1;
                    end else begin
                        pend_c = e + 2; blk++; pend_wr = has_wr;
                    end
                end
            end
            if (infl && c <= fend) begin
                chk(infl_wr ? "wr_addr_hold" : "rd_addr_hold", infl_wr ? start_wr_addr : start_rd_addr, ia);
                chk(infl_wr ? "wr_len_hold" : "rd_len_hold", infl_wr ? wr_length : rd_length, l);
            end
            cfg_start = c == 0 || (post && c == fin_c);
            if (c == 0) drive_cfg(b, l, n, m, t);
            else drive_cfg(49'({$urandom, $urandom}), $urandom, 16'($urandom), 2'($urandom), 24'($urandom));
            cfg_abort = ab || (c > fin_c && $urandom_range(0, 3) == 0);
            gdma_wr_done = (infl && infl_wr && (c == dc || c == late_c)) ||
                           (infl && !infl_wr && c <= fend && $urandom_range(0, 3) == 0);
            gdma_rd_done = (infl && !infl_wr && (c == dc || c == late_c)) ||
                           (infl && infl_wr && c <= fend && $urandom_range(0, 3) == 0);
            c++;
            if (c > 5000) begin
                checks++;
                errors++;
                $display("FAIL run_timeout: no done after %0d cycles", c);
                break;
            end
        end
        last_err = exp_err;
        fin_off = fin_c;
        cfg_start = 0; cfg_abort = 0; gdma_wr_done = 0; gdma_rd_done = 0;
    endtask

    task automatic rand_run();
        logic [31:0] l;
        logic [23:0] t;
        int ab, f;
        bit hold;
        l = $urandom_range(0, 7) == 0 ? 32'd0 : 32'($urandom_range(1, 32'hFFFF));
        t = $urandom_range(0, 3) == 0 ? 24'd0 : 24'($urandom_range(2, 14));
        hold = t != 0 && $urandom_range(0, 5) == 0;
        ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 4)) : -1;
        run(49'({$urandom, $urandom}), l, 16'($urandom_range(0, 5)), 2'($urandom), t, -1, hold, ab,
            bit'($urandom_range(0, 1)), f);
    endtask

    initial begin
        gdma_rst = 1; cfg_start = 0; cfg_abort = 0; gdma_wr_done = 0; gdma_rd_done = 0;
        drive_cfg('0, '0, '0, '0, '0);
        repeat (3) @(negedge gdma_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_wr_start", gdma_wr_start, 0);
        chk("rst_rd_start", gdma_rd_start, 0);
        chk("rst_wr_addr", start_wr_addr, 0);
        chk("rst_rd_len", rd_length, 0);
        gdma_rst = 0;

        // write-then-read, 3 blocks, done 5 cycles after each start
        run(49'h1000, 32'h400, 16'd3, 2'b10, 24'd0, 5, 0, -1, 0, fo);
        chk("t1_fin_off", fo, 40);
        chk("t1_jobs", q_addr.size(), 6);
        for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
            chk("t1_addr", q_addr[i], 49'h1000 + 49'((i / 2) * 32'h400));
            chk("t1_is_wr", q_wr[i], i % 2 == 0);
        end
        chk("t1_blk_cnt", blk_cnt, 3);

        run(49'h500, 32'h100, 16'd0, 2'b10, 24'd0, -1, 0, -1, 0, fo);
        chk("t2_num0_fin_off", fo, 1);
        chk("t2_num0_jobs", q_addr.size(), 0);
        run(49'h500, 32'h0, 16'd5, 2'b00, 24'd0, -1, 0, -1, 1, fo);
        chk("t2_len0_fin_off", fo, 1);
        chk("t2_len0_jobs", q_addr.size(), 0);

        // read-only with rd_done withheld: watchdog fires 20 cycles after the start
        run(49'h2000, 32'h80, 16'd2, 2'b01, 24'd20, 0, 1, -1, 0, fo);
        chk("t3_fin_off", fo, 21);
        chk("t3_error", error, 1);
        chk("t3_jobs", q_addr.size(), 1);

        // zero-latency done in every issue cycle; error must clear on this start
        run(49'h3000, 32'h40, 16'd3, 2'b10, 24'd30, 0, 0, -1, 1, fo);
        chk("t4_fin_off", fo, 16);
        chk("t4_error", error, 0);

        run(49'h1_FFFF_FFFF_FF00, 32'h100, 16'd2, 2'b00, 24'd0, -1, 0, -1, 0, fo);
        chk("t5_jobs", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            chk("t5_addr0", q_addr[0], 49'h1_FFFF_FFFF_FF00);
            chk("t5_addr1_wrap", q_addr[1], 49'h0);
        end

        run(49'h8000, 32'h200, 16'd4, 2'b10, 24'd0, -1, 0, 1, 0, fo);
        chk("t6_blk_cnt", blk_cnt, 2);
        chk("t6_jobs", q_addr.size(), 4);

        for (int r = 0; r < 40; r++) rand_run();

        // reset in the middle of a job
        drive_cfg(49'h4000, 32'h40, 16'd4, 2'b00, 24'd0);
        cfg_start = 1;
        @(negedge gdma_clk);
        cfg_start = 0;
        for (int i = 0; i < 10 && !gdma_wr_start; i++) @(negedge gdma_clk);
        chk("mr_started", gdma_wr_start, 1);
        gdma_rst = 1;
        @(negedge gdma_clk);
        gdma_rst = 0;
        chk("mr_busy", busy, 0);
        chk("mr_wr_start", gdma_wr_start, 0);
        chk("mr_wr_addr", start_wr_addr, 0);
        chk("mr_wr_len", wr_length, 0);
        chk("mr_blk_cnt", blk_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge gdma_clk);
            chk("mr_idle_start", gdma_wr_start | gdma_rd_start | busy, 0);
        end
        last_err = 0;
        run(49'h6000, 32'h10, 16'd2, 2'b11, 24'd9, -1, 0, -1, 0, fo);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
